// File: rtl/tlb_pkg.sv
// TLB controller shared types: op codes, entry layout, FSM states.
// Imported by the request interface, the fill counter and tlb_ctrl.
package tlb_pkg;

    localparam int TLBNUM_DEF = 16;
    localparam int IDXW       = $clog2(TLBNUM_DEF);

    localparam int VPPN_W = 19;
    localparam int ASID_W = 10;
    localparam int PS_W   = 6;
    localparam int PPN_W  = 20;
    localparam int INVOP_W = 5;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    localparam logic [INVOP_W-1:0] INV_OP_MAX = 5'd6;

    // 89 bits, e is the MSB
    typedef struct packed {
        logic              e;
        logic [VPPN_W-1:0] vppn;
        logic [PS_W-1:0]   ps;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [PPN_W-1:0]  ppn0;
        logic [1:0]        plv0;
        logic [1:0]        mat0;
        logic              d0;
        logic              v0;
        logic [PPN_W-1:0]  ppn1;
        logic [1:0]        plv1;
        logic [1:0]        mat1;
        logic              d1;
        logic              v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_e;

    function automatic logic op_err(input logic [2:0] op,
                                    input logic [INVOP_W-1:0] inv_op);
        return (op > OP_INV) || ((op == OP_INV) && (inv_op > INV_OP_MAX));
    endfunction

endpackage

// File: rtl/tlb_req_if.sv
// Request/response handshake between a requester and tlb_ctrl.
// master: requester side; slave: tlb_ctrl side.
interface tlb_req_if
    import tlb_pkg::*;
#(
    parameter int TLBNUM = TLBNUM_DEF
) ();
    localparam int IW = $clog2(TLBNUM);

    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_op;
    logic [IW-1:0]      req_index;
    tlb_entry_t         req_entry;
    logic [INVOP_W-1:0] req_inv_op;
    logic [ASID_W-1:0]  req_asid;
    logic [VPPN_W-1:0]  req_vppn;

    logic               resp_valid;
    logic [2:0]         resp_op;
    logic               resp_err;
    logic               resp_found;
    logic [IW-1:0]      resp_index;
    tlb_entry_t         resp_entry;

    modport master (
        output req_valid, req_op, req_index, req_entry,
        output req_inv_op, req_asid, req_vppn,
        input  req_ready,
        input  resp_valid, resp_op, resp_err, resp_found,
        input  resp_index, resp_entry
    );

    modport slave (
        input  req_valid, req_op, req_index, req_entry,
        input  req_inv_op, req_asid, req_vppn,
        output req_ready,
        output resp_valid, resp_op, resp_err, resp_found,
        output resp_index, resp_entry
    );

endinterface

// File: rtl/tlb_fill_ctr.sv
// Free-running fill index counter, wraps TLBNUM-1 -> 0.
// Ports: clk, resetn, cnt (current fill index).
module tlb_fill_ctr
    import tlb_pkg::*;
#(
    parameter int TLBNUM = TLBNUM_DEF,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    output logic [IW-1:0] cnt
);
    logic [IW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == IW'(TLBNUM - 1)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tlb_ctrl.sv
// TLB op sequencer: IDLE -> ISSUE -> RESP for SRCH/RD/WR/FILL/INV.
// Ports: clk, resetn, req (slave), TLB search/read/write/inv ports, cancel.
module tlb_ctrl
    import tlb_pkg::*;
#(
    parameter int TLBNUM = TLBNUM_DEF,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic               clk,
    input  logic               resetn,
    tlb_req_if.slave           req,
    output logic [VPPN_W-1:0]  tlb_s_vppn,
    output logic [ASID_W-1:0]  tlb_s_asid,
    input  logic               tlb_s_found,
    input  logic [IW-1:0]      tlb_s_index,
    output logic [IW-1:0]      tlb_r_index,
    input  tlb_entry_t         tlb_r_entry,
    output logic               tlb_we,
    output logic [IW-1:0]      tlb_w_index,
    output tlb_entry_t         tlb_w_entry,
    output logic               tlb_inv_valid,
    output logic [INVOP_W-1:0] tlb_inv_op,
    input  logic               cancel
);
    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               err_q, err_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      widx_q, widx_d;
    tlb_entry_t         entry_q, entry_d;
    logic [INVOP_W-1:0] inv_op_q, inv_op_d;
    logic [ASID_W-1:0]  asid_q, asid_d;
    logic [VPPN_W-1:0]  vppn_q, vppn_d;

    logic               rvalid_q, rvalid_d;
    logic [2:0]         rop_q, rop_d;
    logic               rerr_q, rerr_d;
    logic               rfound_q, rfound_d;
    logic [IW-1:0]      ridx_q, ridx_d;
    tlb_entry_t         rentry_q, rentry_d;

    logic [IW-1:0]      fill_cnt;
    logic               issue;

    tlb_fill_ctr #(.TLBNUM(TLBNUM)) u_fill (
        .clk    (clk),
        .resetn (resetn),
        .cnt    (fill_cnt)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        err_d    = err_q;
        idx_d    = idx_q;
        widx_d   = widx_q;
        entry_d  = entry_q;
        inv_op_d = inv_op_q;
        asid_d   = asid_q;
        vppn_d   = vppn_q;
        rvalid_d = 1'b0;
        rop_d    = rop_q;
        rerr_d   = rerr_q;
        rfound_d = rfound_q;
        ridx_d   = ridx_q;
        rentry_d = rentry_q;
        unique case (state_q)
            S_IDLE: begin
                if (req.req_valid) begin
                    state_d  = S_ISSUE;
                    op_d     = req.req_op;
                    err_d    = op_err(req.req_op, req.req_inv_op);
                    idx_d    = req.req_index;
                    // FILL targets the counter value seen at acceptance
                    widx_d   = (req.req_op == OP_FILL) ? fill_cnt
                                                       : req.req_index;
                    entry_d  = req.req_entry;
                    inv_op_d = req.req_inv_op;
                    asid_d   = req.req_asid;
                    vppn_d   = req.req_vppn;
                end
            end
            S_ISSUE: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rop_d    = err_q ? 3'd0 : op_q;
                    rerr_d   = err_q;
                    rfound_d = 1'b0;
                    ridx_d   = '0;
                    rentry_d = '0;
                    if (!err_q) begin
                        case (op_q)
                            OP_SRCH: begin
                                rfound_d = tlb_s_found;
                                ridx_d   = tlb_s_found ? tlb_s_index : '0;
                            end
                            OP_RD: begin
                                rfound_d = tlb_r_entry.e;
                                rentry_d = tlb_r_entry.e ? tlb_r_entry : '0;
                            end
                            OP_FILL: ridx_d = widx_q;
                            default: ;
                        endcase
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            widx_q   <= '0;
            entry_q  <= '0;
            inv_op_q <= '0;
            asid_q   <= '0;
            vppn_q   <= '0;
            rvalid_q <= 1'b0;
            rop_q    <= '0;
            rerr_q   <= 1'b0;
            rfound_q <= 1'b0;
            ridx_q   <= '0;
            rentry_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            widx_q   <= widx_d;
            entry_q  <= entry_d;
            inv_op_q <= inv_op_d;
            asid_q   <= asid_d;
            vppn_q   <= vppn_d;
            rvalid_q <= rvalid_d;
            rop_q    <= rop_d;
            rerr_q   <= rerr_d;
            rfound_q <= rfound_d;
            ridx_q   <= ridx_d;
            rentry_q <= rentry_d;
        end
    end

    // cancel gates the strobes combinationally within ISSUE
    assign issue = (state_q == S_ISSUE) && !err_q && !cancel;

    assign tlb_we        = issue && ((op_q == OP_WR) || (op_q == OP_FILL));
    assign tlb_inv_valid = issue && (op_q == OP_INV);
    assign tlb_s_vppn    = vppn_q;
    assign tlb_s_asid    = asid_q;
    assign tlb_r_index   = idx_q;
    assign tlb_w_index   = widx_q;
    assign tlb_w_entry   = entry_q;
    assign tlb_inv_op    = inv_op_q;

    assign req.req_ready  = (state_q == S_IDLE);
    assign req.resp_valid = rvalid_q;
    assign req.resp_op    = rop_q;
    assign req.resp_err   = rerr_q;
    assign req.resp_found = rfound_q;
    assign req.resp_index = ridx_q;
    assign req.resp_entry = rentry_q;

endmodule

// File: doc/tlb_ctrl.md
TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 SHALL have parameter: TLBNUM, 16, number of TLB entries; IDXW = clog2(TLBNUM), derived.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk, resetn.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 req_valid/req_ready  in/out  1/1  op request handshake.
REQ-006 req_op  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV.
REQ-007 req_index in IDXW; req_entry in 89 (packed tlb_entry_t); req_inv_op in 5; req_asid in 10; req_vppn in 19.
REQ-008 tlb_s_vppn out 19, tlb_s_asid out 10, tlb_s_found in 1, tlb_s_index in IDXW; search-port-1 / invtlb operand drive.
REQ-009 tlb_r_index out IDXW, tlb_r_entry in 89; read port.
REQ-010 tlb_we out 1, tlb_w_index out IDXW, tlb_w_entry out 89; write port.
REQ-011 tlb_inv_valid out 1, tlb_inv_op out 5; invalidate port.
REQ-012 cancel in 1; pipeline flush.
REQ-013 resp_valid out 1, resp_op out 3, resp_err out 1, resp_found out 1, resp_index out IDXW, resp_entry out 89; result, one-cycle pulse, no back-pressure.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, RESP; req_ready = (state==IDLE).
REQ-015 Accept at cycle T (IDLE, req_valid&&req_ready) SHALL register all req_* fields and enter ISSUE at T+1.
REQ-016 In ISSUE, TLB port outputs SHALL come only from registered fields, constant for the whole cycle.
REQ-017 SRCH: tlb_s_vppn/asid driven in ISSUE; tlb_s_found/index sampled at end of ISSUE; resp_found=found, resp_index=found?index:0.
REQ-018 RD: tlb_r_index=req_index; sampled entry.e=1 -> resp_found=1, resp_entry=entry; e=0 -> resp_found=0, resp_entry=0.
REQ-019 WR: tlb_we=1 for exactly one cycle (ISSUE), tlb_w_index=req_index, tlb_w_entry=req_entry.
REQ-020 FILL: as WR but tlb_w_index = fill counter value sampled at acceptance cycle; resp_index reports it.
REQ-021 Fill counter SHALL increment every cycle, wrapping TLBNUM-1 -> 0.
REQ-022 INV: tlb_inv_valid=1 one cycle in ISSUE with tlb_inv_op=req_inv_op, tlb_s_asid=req_asid, tlb_s_vppn=req_vppn.
REQ-023 req_op>4, or INV with req_inv_op>6: no TLB port activity; resp_err=1, other resp fields 0.
REQ-024 RESP: resp_valid=1 for exactly one cycle at T+2, then IDLE; next accept no earlier than T+3.
REQ-025 cancel=1 in ISSUE SHALL suppress tlb_we/tlb_inv_valid in that cycle (combinational gating), skip RESP, return to IDLE.
REQ-026 cancel in IDLE or RESP SHALL have no effect.
REQ-027 Outside ISSUE, tlb_we=0 and tlb_inv_valid=0; addresses/operands hold last registered values.

Reset
REQ-028 Reset SHALL force IDLE, fill counter 0, all registered fields 0, all outputs 0 except req_ready=1.
REQ-029 Reset asserted mid-operation SHALL abort it: no write, invalidate or response after reset deassertion.

Structure
REQ-030 Shared package tlb_pkg SHALL hold TLBNUM default, IDXW, op encodings, tlb_entry_t field widths/offsets (e,vppn,ps,asid,g,ppn0,plv0,mat0,d0,v0,ppn1,plv1,mat1,d1,v1 = 89 bits), FSM state type.
REQ-031 Fill counter SHALL be sub-module tlb_fill_ctr; all else in tlb_ctrl.

Verification
REQ-032 SRCH vppn=0x12345, asid=5, TLB model hit at index 7 -> resp at T+2: found=1, index=7, err=0.
REQ-033 WR index=3, entry.e=1, ppn0=0xABCDE -> tlb_we high exactly at T+1 with index 3; RD index 3 then returns that entry with found=1.
REQ-034 FILL accepted when counter=15 -> tlb_w_index=15, resp_index=15; next FILL confirms counter wrapped through 0.
REQ-035 INV op=5, asid=2, vppn=0x00400 -> tlb_inv_valid one cycle at T+1 with op 5, asid 2, vppn 0x00400; INV op=7 -> no inv pulse, resp_err=1.
REQ-036 WR with cancel=1 during ISSUE -> tlb_we never high, no resp_valid, req_ready=1 at T+2.
REQ-037 resetn low during ISSUE of WR -> no tlb_we, no resp_valid after release; req_ready=1, counter=0.
